// File: rtl/game_mem_pkg.sv
// Shared definitions for the game_mem arbiter: FSM state encoding, requester
// indices and default widths. Build option GAME_MEM_ARB_RR_EN selects
// round-robin arbitration (see mem_arb_select / game_mem_arbiter).
package game_mem_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;
    localparam int N_REQ_DEF  = 3;

    // Requester port assignments
    localparam int REQ_SCORE = 0;
    localparam int REQ_TOP   = 1;
    localparam int REQ_HEX   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RD_DONE = 2'd3
    } arb_state_t;

    // Index width for a requester count; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner selection for the game_mem arbiter.
// Requesters are scanned circularly starting one past a start index.
// With GAME_MEM_ARB_RR_EN defined the start index is the round-robin pointer;
// otherwise it is pinned to N_REQ-1 so the scan is 0,1,2,... (fixed priority)
// and the pointer input is ignored.
module mem_arb_select
    import game_mem_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_any,
    output logic [IDX_W-1:0] o_winner
);

    logic [IDX_W-1:0] w_start;

`ifdef GAME_MEM_ARB_RR_EN
    assign w_start = i_ptr;
`else
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;
    assign w_start      = IDX_W'(N_REQ - 1);
`endif

    // Walk the requesters in circular order after w_start; first request seen wins.
    always_comb begin
        logic [IDX_W-1:0] v_idx;
        o_any    = 1'b0;
        o_winner = '0;
        v_idx    = w_start;
        for (int k = 0; k < N_REQ; k++) begin
            v_idx = (v_idx == IDX_W'(N_REQ - 1)) ? '0 : v_idx + IDX_W'(1);
            if (!o_any && i_req[v_idx]) begin
                o_any    = 1'b1;
                o_winner = v_idx;
            end
        end
    end

endmodule

// File: rtl/game_mem_arbiter.sv
// Single-port arbiter in front of game_mem (synchronous RAM, one-cycle read).
// One access outstanding at a time: IDLE arbitrates, GRANT drives the memory,
// reads then spend RD_WAIT (mem_q valid) and RD_DONE (rvalid pulse).
// Build option GAME_MEM_ARB_RR_EN: round-robin instead of fixed 0>1>2 priority.
module game_mem_arbiter
    import game_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_REQ  = N_REQ_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        we,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]       rdata,
    output logic                    busy,
    output logic [ADDR_W-1:0]       mem_address,
    output logic [DATA_W-1:0]       mem_data,
    output logic                    mem_wren,
    input  logic [DATA_W-1:0]       mem_q
);

    localparam int IDX_W = idx_width(N_REQ);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic [IDX_W-1:0]  r_winner;
    logic              r_we;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_mem_wren;
    logic [DATA_W-1:0] r_rdata;

    logic              w_any;
    logic [IDX_W-1:0]  w_sel;
    logic              w_arb;
    logic [IDX_W-1:0]  w_ptr;
    logic [N_REQ-1:0]  w_winner_1h;

    logic [ADDR_W-1:0] w_addr_arr  [N_REQ];
    logic [DATA_W-1:0] w_wdata_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_addr_arr[g]  = addr[g*ADDR_W +: ADDR_W];
        assign w_wdata_arr[g] = wdata[g*DATA_W +: DATA_W];
    end

`ifdef GAME_MEM_ARB_RR_EN
    logic [IDX_W-1:0] r_ptr;

    // Remember the last winner so the next search starts just past it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= IDX_W'(N_REQ - 1);
        end else if (w_arb) begin
            r_ptr <= w_sel;
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = IDX_W'(N_REQ - 1);
`endif

    mem_arb_select #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_select (
        .i_req    (req),
        .i_ptr    (w_ptr),
        .o_any    (w_any),
        .o_winner (w_sel)
    );

    // Arbitration happens only when idle; requests seen in other states wait.
    assign w_arb       = (r_state == ST_IDLE) && w_any;
    assign w_winner_1h = N_REQ'(1) << r_winner;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: writes finish in GRANT, reads walk through RD_WAIT/RD_DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (w_any) w_next_state = ST_GRANT;
            ST_GRANT:   w_next_state = r_we ? ST_IDLE : ST_RD_WAIT;
            ST_RD_WAIT: w_next_state = ST_RD_DONE;
            ST_RD_DONE: w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Output decode: grant pulse in GRANT, read-valid pulse in RD_DONE.
    always_comb begin
        gnt    = '0;
        rvalid = '0;
        busy   = (r_state != ST_IDLE);
        case (r_state)
            ST_GRANT:   gnt    = w_winner_1h;
            ST_RD_DONE: rvalid = w_winner_1h;
            default:    ;
        endcase
    end

    // Latch the winning access, drive the memory port, and capture read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_winner      <= '0;
            r_we          <= 1'b0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
            r_mem_wren    <= 1'b0;
            r_rdata       <= '0;
        end else begin
            r_mem_wren <= 1'b0;
            if (w_arb) begin
                r_winner      <= w_sel;
                r_we          <= we[w_sel];
                r_mem_address <= w_addr_arr[w_sel];
                r_mem_data    <= w_wdata_arr[w_sel];
                r_mem_wren    <= we[w_sel];
            end
            if (r_state == ST_RD_WAIT) begin
                r_rdata <= mem_q;
            end
        end
    end

    assign mem_address = r_mem_address;
    assign mem_data    = r_mem_data;
    assign mem_wren    = r_mem_wren;
    assign rdata       = r_rdata;

endmodule

// File: tb/tb_game_mem_arbiter.sv
// Self-checking bench for game_mem_arbiter with a behavioural game_mem and a
// transaction-level reference model. Build with +define+GAME_MEM_ARB_RR_EN
// to exercise the round-robin variant.
module tb_game_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int NR = 3;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [NR-1:0] req   = '0;
    logic [NR-1:0] we    = '0;
    logic [AW-1:0] a_addr  [NR];
    logic [DW-1:0] a_wdata [NR];
    logic [NR*AW-1:0] addr;
    logic [NR*DW-1:0] wdata;

    logic [NR-1:0] gnt, rvalid;
    logic [DW-1:0] rdata, mem_data, mem_q;
    logic [AW-1:0] mem_address;
    logic          busy, mem_wren;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;
    bit hold   = 1'b0;
    logic [NR-1:0] prev_gnt = '0;
    int glog[$];
    int rv_count = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            addr[i*AW +: AW]  = a_addr[i];
            wdata[i*DW +: DW] = a_wdata[i];
        end
    end

    game_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .N_REQ(NR)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .busy        (busy),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    // Behavioural game_mem: synchronous write, registered read.
    logic [DW-1:0] ram [32];
    always @(posedge clk) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        mem_q <= ram[mem_address];
    end

    function automatic logic [DW-1:0] init_val(input int i);
        return (i == 1) ? 8'h2A : 8'(8'h40 + i);
    endfunction

    // ---------------- reference model ----------------
    // An access occupies the port for m_len cycles after it is granted
    // (write 1, read 3); m_k counts cycles into the access, 0 = idle.
    function automatic int pick(input logic [NR-1:0] r, input int last);
        int res = -1;
        int c;
`ifdef GAME_MEM_ARB_RR_EN
        for (int s = 1; s <= NR; s++) begin
            c = (last + s) % NR;
            if (res < 0 && r[c]) res = c;
        end
`else
        c = last;
        for (int s = 0; s < NR; s++) if (res < 0 && r[s]) res = s;
`endif
        return res;
    endfunction

    int            m_k, m_len, m_who, m_last, m_pick;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, m_rdata;
    logic [DW-1:0] m_mem [32];

    always_comb m_pick = pick(req, m_last);

    always @(posedge clk) begin
        if (reset) begin
            m_k <= 0; m_len <= 0; m_who <= 0; m_last <= NR - 1;
            m_we <= 1'b0; m_addr <= '0; m_data <= '0; m_rdata <= '0;
        end else if (m_k == 0) begin
            if (req != '0) begin
                m_who  <= m_pick;
                m_last <= m_pick;
                m_we   <= we[m_pick];
                m_addr <= a_addr[m_pick];
                m_data <= a_wdata[m_pick];
                m_len  <= we[m_pick] ? 1 : 3;
                m_k    <= 1;
            end
        end else if (m_k < m_len) begin
            m_k <= m_k + 1;
            if (m_k == 2) m_rdata <= m_mem[m_addr];
        end else begin
            m_k <= 0;
            if (m_we) m_mem[m_addr] <= m_data;
        end
    end

    wire [NR-1:0] e_1h    = NR'(1) << m_who;
    wire [NR-1:0] e_gnt   = (m_k == 1) ? e_1h : '0;
    wire [NR-1:0] e_rv    = (m_k == 3) ? e_1h : '0;
    wire          e_wren  = (m_k == 1) && m_we;
    wire          e_busy  = (m_k != 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_gnt",    32'(gnt),         32'(e_gnt));
            chk("m_rvalid", 32'(rvalid),      32'(e_rv));
            chk("m_busy",   32'(busy),        32'(e_busy));
            chk("m_wren",   32'(mem_wren),    32'(e_wren));
            chk("m_addr",   32'(mem_address), 32'(m_addr));
            chk("m_data",   32'(mem_data),    32'(m_data));
            chk("m_rdata",  32'(rdata),       32'(m_rdata));
        end
    end

    // One clock; requesters drop req the cycle after their grant unless held.
    task automatic step();
        @(posedge clk);
        #1;
        if (!hold) req = req & ~prev_gnt;
        prev_gnt = gnt;
        for (int i = 0; i < NR; i++) if (gnt[i]) glog.push_back(i);
        if (rvalid != '0) rv_count++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        hold  = 1'b0;
        step();
        chk_on = 1'b1;
        step();
        reset    = 1'b0;
        prev_gnt = '0;
        glog.delete();
    endtask

    int exp_c[4] = '{0, 1, 2, 0};
`ifdef GAME_MEM_ARB_RR_EN
    int exp_f[6] = '{0, 1, 0, 1, 0, 1};
`else
    int exp_f[6] = '{0, 0, 0, 0, 0, 0};
`endif

    initial begin
        for (int i = 0; i < 32; i++) begin
            ram[i]   <= init_val(i);
            m_mem[i] <= init_val(i);
        end
        for (int i = 0; i < NR; i++) begin
            a_addr[i]  = '0;
            a_wdata[i] = '0;
        end

        // Reset state
        do_reset();
        chk("rst_busy",  32'(busy), 0);
        chk("rst_gnt",   32'(gnt), 0);
        chk("rst_wren",  32'(mem_wren), 0);
        chk("rst_rdata", 32'(rdata), 0);

        // Single write from requester 0
        we = 3'b001; a_addr[0] = 5'd0; a_wdata[0] = 8'h05; req = 3'b001;
        step();
        chk("wr_gnt",   32'(gnt), 32'h1);
        chk("wr_wren",  32'(mem_wren), 1);
        chk("wr_addr",  32'(mem_address), 0);
        chk("wr_data",  32'(mem_data), 32'h05);
        chk("wr_busy",  32'(busy), 1);
        step();
        chk("wr_wren_off", 32'(mem_wren), 0);
        chk("wr_busy_off", 32'(busy), 0);
        step(); step();
        chk("wr_ram0",  32'(ram[0]), 32'h05);
        chk("wr_once",  32'(glog.size()), 1);

        // Single read from requester 2
        do_reset();
        we = 3'b000; a_addr[2] = 5'd1; req = 3'b100;
        step();
        chk("rd_gnt",    32'(gnt), 32'h4);
        chk("rd_rv0",    32'(rvalid), 0);
        step();
        chk("rd_rv1",    32'(rvalid), 0);
        step();
        chk("rd_rvalid", 32'(rvalid), 32'h4);
        chk("rd_rdata",  32'(rdata), 32'h2A);
        step();
        chk("rd_rv_off", 32'(rvalid), 0);
        chk("rd_hold",   32'(rdata), 32'h2A);

        // Reset while a read is in RD_WAIT
        glog.delete();
        we = 3'b000; a_addr[0] = 5'd3; a_wdata[0] = 8'h77; req = 3'b001;
        step();
        chk("rr_gnt", 32'(gnt), 32'h1);
        step();
        rv_count = 0;
        reset = 1'b1;
        step();
        chk("rr_busy",  32'(busy), 0);
        chk("rr_rv",    32'(rvalid), 0);
        chk("rr_rdata", 32'(rdata), 0);
        chk("rr_addr",  32'(mem_address), 0);
        chk("rr_data",  32'(mem_data), 0);
        chk("rr_wren",  32'(mem_wren), 0);
        reset = 1'b0;
        repeat (4) step();
        chk("rr_no_rvalid", 32'(rv_count), 0);

        // Three-way contention, then everyone requests again
        do_reset();
        we = 3'b111;
        a_addr[0] = 5'd10; a_addr[1] = 5'd11; a_addr[2] = 5'd12;
        a_wdata[0] = 8'hA1; a_wdata[1] = 8'hA2; a_wdata[2] = 8'hA3;
        req = 3'b111;
        for (int n = 0; n < 30 && glog.size() < 3; n++) step();
        step();
        req = 3'b111;
        for (int n = 0; n < 30 && glog.size() < 4; n++) step();
        chk("ct_count", 32'(glog.size()), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) chk("ct_order", 32'(glog[i]), 32'(exp_c[i]));
        chk("ct_ram12", 32'(ram[12]), 32'hA3);

        // Two requesters holding req continuously
        do_reset();
        hold = 1'b1;
        we = 3'b011; a_addr[0] = 5'd20; a_addr[1] = 5'd21;
        a_wdata[0] = 8'hB0; a_wdata[1] = 8'hB1;
        req = 3'b011;
        for (int n = 0; n < 40 && glog.size() < 6; n++) step();
        hold = 1'b0;
        req  = 3'b000;
        chk("fair_count", 32'(glog.size() >= 6), 1);
        for (int i = 0; i < 6 && i < glog.size(); i++) chk("fair_order", 32'(glog[i]), 32'(exp_f[i]));

        // Short-lived request during a read is withdrawn silently
        do_reset();
        we = 3'b010; a_addr[1] = 5'd7; a_wdata[1] = 8'hFF; a_addr[2] = 5'd1;
        req = 3'b100;
        step();
        step();
        req = req | 3'b010;
        step();
        req = req & 3'b101;
        repeat (5) step();
        chk("wd_grants", 32'(glog.size()), 1);
        if (glog.size() > 0) chk("wd_who", 32'(glog[0]), 2);
        chk("wd_ram7",   32'(ram[7]), 32'(init_val(7)));
        chk("wd_rdata",  32'(rdata), 32'h2A);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/game_mem_arbiter.md
GAME_MEM_ARBITER -- requirements
Module: game_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, game_mem address width (32 words).
REQ-002 Parameter DATA_W, default 8, game_mem word width.
REQ-003 Parameter N_REQ, default 3, requester count; port 0 = datapath score, 1 = top-score update, 2 = hex display.
REQ-004 clk  in  1  system clock (CLOCK_50 domain); single clock, all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  N_REQ  per-requester access request, held until matching gnt.
REQ-007 we  in  N_REQ  per-requester write (1) / read (0) qualifier.
REQ-008 addr  in  N_REQ*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-009 wdata  in  N_REQ*DATA_W  packed write data, same packing.
REQ-010 gnt  out  N_REQ  one-hot, one-cycle grant pulse.
REQ-011 rvalid  out  N_REQ  one-hot, one-cycle read-data-valid pulse.
REQ-012 rdata  out  DATA_W  read data, valid while any rvalid bit high.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 mem_address / mem_data / mem_wren  out  ADDR_W / DATA_W / 1  to game_mem, all registered.
REQ-015 mem_q  in  DATA_W  game_mem output, valid one cycle after mem_address is presented.

Function
REQ-016 FSM states IDLE, GRANT, RD_WAIT, RD_DONE; arbitration only in IDLE.
REQ-017 IDLE with any req at edge T: winner latched; at T+1 state GRANT, gnt[winner]=1, mem_address/mem_data driven from winner, mem_wren=we[winner].
REQ-018 GRANT with write: next state IDLE; mem_wren high exactly one cycle; writes take 2 cycles, back-to-back.
REQ-019 GRANT with read: next RD_WAIT (mem_q valid), rdata registered from mem_q at end of RD_WAIT, RD_DONE asserts rvalid[winner] one cycle, then IDLE; read latency gnt to rvalid = 2 cycles.
REQ-020 Requester drops req in the cycle after gnt; req high while gnt high is not a new request.
REQ-021 req deasserted before grant is withdrawn without side effects.
REQ-022 Requests arriving during GRANT/RD_WAIT/RD_DONE wait; at most one access outstanding.
REQ-023 Fixed priority (macro absent): 0 > 1 > 2.
REQ-024 mem_wren is 0 in every state except a write GRANT; mem_address/mem_data hold last values otherwise.
REQ-025 rdata holds last read value until next RD_DONE.

Reset
REQ-026 reset forces state IDLE, gnt=0, rvalid=0, rdata=0, busy=0, mem_address=0, mem_data=0, mem_wren=0, RR pointer=N_REQ-1.
REQ-027 reset mid-read: no rvalid issued, pending access discarded; reset dominates all inputs in the same cycle.

Configuration
REQ-028 Macro GAME_MEM_ARB_RR_EN: defined = round-robin, search starts at (last granted+1) mod N_REQ, pointer updated on every gnt; undefined = fixed priority per REQ-023, no pointer register.

Structure
REQ-029 Shared package game_mem_pkg holds FSM state enum, requester index constants (REQ_SCORE=0, REQ_TOP=1, REQ_HEX=2), ADDR_W/DATA_W defaults.
REQ-030 One sub-module mem_arb_select: combinational winner selection from req and pointer (pointer ignored when macro undefined).

Verification
REQ-031 Write: req0=1, we0=1, addr0=0, wdata0=8'h05 -> gnt[0] next cycle, mem_wren=1 one cycle, mem_address=0, mem_data=8'h05, busy 1 cycle.
REQ-032 Read: memory[1]=8'h2A, req2=1, we2=0, addr2=1 -> gnt[2], rvalid[2] two cycles later with rdata=8'h2A.
REQ-033 Contention: req0,req1,req2 all high same cycle, held -> fixed: grant order 0,1,2; RR: 0,1,2 then 0 again if all re-requested.
REQ-034 RR fairness: req0 and req1 continuously high 6 accesses -> grants alternate 0,1,0,1,0,1; fixed build -> only 0.
REQ-035 reset asserted in RD_WAIT -> next cycle IDLE, no rvalid, all outputs zero.
REQ-036 req1 raised then dropped while read for req2 in progress -> no gnt[1], no memory write.
